modbus_response_tx: RTL and testbench



---
 rtl/modbus_response_tx_pkg.sv | 23 ++
 rtl/modbus_response_tx_crc.sv | 54 +++++
 rtl/modbus_response_tx.sv | 198 +++++++++++++++++++
 tb/tb_modbus_response_tx.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/modbus_response_tx_pkg.sv
// Shared definitions for the Modbus RTU response transmitter: CRC constants,
// controller states and UART framing. Optional macro used by the top: RS485_GUARD_EN.
package modbus_response_tx_pkg;

  localparam logic [15:0] CRC_INIT        = 16'hFFFF;
  localparam logic [15:0] CRC_POLY        = 16'hA001;
  localparam int          UART_FRAME_BITS = 10;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CRC,
    ST_SEND,
    ST_DONE
  } tx_state_e;

  // One reflected CRC-16 step for a single input bit.
  function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic din);
    logic [15:0] shifted;
    shifted = crc >> 1;
    return (crc[0] ^ din) ? (shifted ^ CRC_POLY) : shifted;
  endfunction

endpackage

// File: rtl/modbus_response_tx_crc.sv
// Bit-serial Modbus CRC-16 engine: a byte is accepted when idle and folded in
// one bit per clock, so each byte occupies the engine for 8 clocks.
module tx_crc
  import modbus_response_tx_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        clear_i,
  input  logic        byte_valid_i,
  input  logic [7:0]  byte_i,
  output logic [15:0] crc_o,
  output logic        busy_o
);

  logic [15:0] crc_q, crc_d;
  logic [6:0]  sh_q, sh_d;
  logic [2:0]  cnt_q, cnt_d;

  always_comb begin
    crc_d = crc_q;
    sh_d  = sh_q;
    cnt_d = cnt_q;
    if (clear_i) begin
      crc_d = CRC_INIT;
      sh_d  = 7'd0;
      cnt_d = 3'd0;
    end else if (cnt_q != 3'd0) begin
      crc_d = crc16_step(crc_q, sh_q[0]);
      sh_d  = sh_q >> 1;
      cnt_d = cnt_q - 3'd1;
    end else if (byte_valid_i) begin
      // bit 0 is consumed on the accepting clock, seven remain
      crc_d = crc16_step(crc_q, byte_i[0]);
      sh_d  = byte_i[7:1];
      cnt_d = 3'd7;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      crc_q <= CRC_INIT;
      sh_q  <= 7'd0;
      cnt_q <= 3'd0;
    end else begin
      crc_q <= crc_d;
      sh_q  <= sh_d;
      cnt_q <= cnt_d;
    end
  end

  assign crc_o  = crc_q;
  assign busy_o = (cnt_q != 3'd0);

endmodule

// File: rtl/modbus_response_tx.sv
// Modbus RTU read-registers response transmitter: CRC pass over the frame, then
// 8N1 serialisation on RS-485. Optional macro RS485_GUARD_EN adds driver-enable guard bits.
//
// state   | meaning
// IDLE    | waiting for tx_start, line idle high, driver off
// CRC     | feeding header and RAM data bytes into the CRC engine
// SEND    | serialising the frame (plus guard periods if enabled)
// DONE    | one-clock response_done pulse, then back to IDLE
module modbus_response_tx
  import modbus_response_tx_pkg::*;
#(
  parameter int          CLK_FREQ  = 50000000,
  parameter int          BAUD_RATE = 115200,
  parameter logic [7:0]  SADDR     = 8'h01
) (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic        tx_start,
  input  logic [7:0]  func_code,
  input  logic [7:0]  tx_quantity,
  input  logic [15:0] tx_data,
  output logic [7:0]  tx_addr,
  output logic [15:0] crc_calc,
  output logic        response_done,
  output logic        rs485_tx,
  output logic        rs485_tx_en
);

  localparam int          BIT_CYC    = CLK_FREQ / BAUD_RATE;
  localparam logic [23:0] BIT_RELOAD = 24'(BIT_CYC - 1);
  localparam logic [3:0]  LAST_BIT   = 4'(UART_FRAME_BITS - 1);
`ifdef RS485_GUARD_EN
  localparam bit GUARD_EN = 1'b1;
`else
  localparam bit GUARD_EN = 1'b0;
`endif

  tx_state_e   state_q;
  logic [7:0]  func_q;
  logic [7:0]  qty_q;
  logic [9:0]  idx_q;
  logic [7:0]  tx_addr_q;
  logic        tx_q;
  logic        en_q;
  logic        done_q;
  logic [23:0] baud_q;
  logic [3:0]  bit_q;
  logic [8:0]  shift_q;
  logic        guard_q;

  logic [9:0]  n_bytes;
  logic [9:0]  last_idx;
  logic [7:0]  cur_byte;
  logic [7:0]  addr_next;
  logic [15:0] crc_val;
  logic        crc_busy;
  logic        crc_feed;
  logic        crc_clear;

  assign n_bytes  = 10'd3 + {1'b0, qty_q, 1'b0};
  assign last_idx = n_bytes + 10'd2;

  // Byte idx_q of the frame; data bytes with odd index are high halves.
  always_comb begin
    cur_byte = 8'h00;
    if (idx_q == 10'd0)       cur_byte = SADDR;
    else if (idx_q == 10'd1)  cur_byte = func_q;
    else if (idx_q == 10'd2)  cur_byte = {qty_q[6:0], 1'b0};
    else if (idx_q < n_bytes) cur_byte = idx_q[0] ? tx_data[15:8] : tx_data[7:0];
    else if (idx_q == n_bytes) cur_byte = crc_val[7:0];
    else                      cur_byte = crc_val[15:8];
  end

  // Once a word's low byte is taken, point the RAM at the next word (or park at 0).
  always_comb begin
    addr_next = tx_addr_q;
    if (idx_q >= 10'd4 && idx_q < n_bytes && !idx_q[0]) begin
      addr_next = (({1'b0, tx_addr_q} + 9'd1) < {1'b0, qty_q}) ? (tx_addr_q + 8'd1) : 8'd0;
    end
  end

  assign crc_clear = (state_q == ST_IDLE) && tx_start;
  assign crc_feed  = (state_q == ST_CRC) && !crc_busy && (idx_q != n_bytes);

  tx_crc u_crc (
    .clk_i       (clk_in),
    .rst_ni      (rst_n_in),
    .clear_i     (crc_clear),
    .byte_valid_i(crc_feed),
    .byte_i      (cur_byte),
    .crc_o       (crc_val),
    .busy_o      (crc_busy)
  );

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q   <= ST_IDLE;
      func_q    <= 8'h00;
      qty_q     <= 8'h00;
      idx_q     <= 10'd0;
      tx_addr_q <= 8'h00;
      tx_q      <= 1'b1;
      en_q      <= 1'b0;
      done_q    <= 1'b0;
      baud_q    <= 24'd0;
      bit_q     <= 4'd0;
      shift_q   <= 9'h1FF;
      guard_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (tx_start) begin
            func_q  <= func_code;
            qty_q   <= tx_quantity;
            idx_q   <= 10'd0;
            state_q <= ST_CRC;
          end
        end

        ST_CRC: begin
          if (!crc_busy) begin
            if (idx_q == n_bytes) begin
              state_q <= ST_SEND;
              en_q    <= 1'b1;
              baud_q  <= BIT_RELOAD;
              bit_q   <= 4'd0;
              if (GUARD_EN) begin
                guard_q <= 1'b1;
                idx_q   <= 10'd0;
              end else begin
                tx_q    <= 1'b0;
                shift_q <= {1'b1, SADDR};
                idx_q   <= 10'd1;
              end
            end else begin
              idx_q     <= idx_q + 10'd1;
              tx_addr_q <= addr_next;
            end
          end
        end

        ST_SEND: begin
          if (baud_q != 24'd0) begin
            baud_q <= baud_q - 24'd1;
          end else begin
            baud_q <= BIT_RELOAD;
            if (guard_q) begin
              guard_q <= 1'b0;
              if (idx_q == 10'd0) begin
                tx_q    <= 1'b0;
                shift_q <= {1'b1, cur_byte};
                bit_q   <= 4'd0;
                idx_q   <= 10'd1;
              end else begin
                en_q    <= 1'b0;
                idx_q   <= 10'd0;
                state_q <= ST_DONE;
              end
            end else if (bit_q != LAST_BIT) begin
              bit_q   <= bit_q + 4'd1;
              tx_q    <= shift_q[0];
              shift_q <= {1'b1, shift_q[8:1]};
            end else if (idx_q == last_idx) begin
              if (GUARD_EN) begin
                guard_q <= 1'b1;
              end else begin
                en_q    <= 1'b0;
                idx_q   <= 10'd0;
                state_q <= ST_DONE;
              end
            end else begin
              tx_q      <= 1'b0;
              shift_q   <= {1'b1, cur_byte};
              bit_q     <= 4'd0;
              idx_q     <= idx_q + 10'd1;
              tx_addr_q <= addr_next;
            end
          end
        end

        ST_DONE: begin
          done_q  <= 1'b1;
          state_q <= ST_IDLE;
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign tx_addr       = tx_addr_q;
  assign crc_calc      = crc_val;
  assign response_done = done_q;
  assign rs485_tx      = tx_q;
  assign rs485_tx_en   = en_q;

endmodule

// File: tb/tb_modbus_response_tx.sv
// Directed bench for modbus_response_tx: a default-rate instance for full timing,
// a fast-baud instance for the shorter scenarios, and a standalone CRC engine.
module tb_modbus_response_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] mem [0:255];
  logic [7:0]  q4_tab [0:10] = '{8'h01, 8'h04, 8'h08, 8'h12, 8'h35, 8'h23, 8'h51, 8'h35, 8'h16, 8'hAA, 8'hAA};
  logic [7:0]  cap [0:31];
  logic [7:0]  prev [0:31];
  logic [7:0]  exp_buf [0:31];

  // default-rate DUT
  logic        rst_d_n = 1'b0, d_start = 1'b0;
  logic [7:0]  d_func = 8'h00, d_qty = 8'h00, d_addr;
  logic [15:0] d_data = 16'h0000, d_crc;
  logic        d_done, d_tx, d_en;

  // fast DUT (BIT_CYC = 8)
  logic        rst_f_n = 1'b0, f_start = 1'b0;
  logic [7:0]  f_func = 8'h00, f_qty = 8'h00, f_addr;
  logic [15:0] f_data = 16'h0000, f_crc;
  logic        f_done, f_tx, f_en;

  // standalone CRC engine
  logic        c_clear = 1'b0, c_valid = 1'b0, c_busy;
  logic [7:0]  c_byte = 8'h00;
  logic [15:0] c_crc;

  modbus_response_tx u_dut (
    .clk_in(clk), .rst_n_in(rst_d_n), .tx_start(d_start), .func_code(d_func),
    .tx_quantity(d_qty), .tx_data(d_data), .tx_addr(d_addr), .crc_calc(d_crc),
    .response_done(d_done), .rs485_tx(d_tx), .rs485_tx_en(d_en)
  );

  modbus_response_tx #(.CLK_FREQ(800), .BAUD_RATE(100), .SADDR(8'h5A)) u_fast (
    .clk_in(clk), .rst_n_in(rst_f_n), .tx_start(f_start), .func_code(f_func),
    .tx_quantity(f_qty), .tx_data(f_data), .tx_addr(f_addr), .crc_calc(f_crc),
    .response_done(f_done), .rs485_tx(f_tx), .rs485_tx_en(f_en)
  );

  tx_crc u_crc_only (
    .clk_i(clk), .rst_ni(rst_d_n), .clear_i(c_clear), .byte_valid_i(c_valid),
    .byte_i(c_byte), .crc_o(c_crc), .busy_o(c_busy)
  );

  always @(posedge clk) begin
    d_data <= mem[d_addr];
    f_data <= mem[f_addr];
  end

  int done_cnt_d = 0, done_cnt_f = 0;
  always @(posedge clk) begin
    if (d_done === 1'b1) done_cnt_d <= done_cnt_d + 1;
    if (f_done === 1'b1) done_cnt_f <= done_cnt_f + 1;
  end

  bit   use_fast = 1'b0;
  logic mon_tx, mon_en, mon_done;
  assign mon_tx   = use_fast ? f_tx   : d_tx;
  assign mon_en   = use_fast ? f_en   : d_en;
  assign mon_done = use_fast ? f_done : d_done;

  function automatic logic [15:0] crc_model(input int nb);
    logic [15:0] crc;
    crc = 16'hFFFF;
    for (int i = 0; i < nb; i++) begin
      crc = crc ^ {8'h00, exp_buf[i]};
      for (int j = 0; j < 8; j++) crc = crc[0] ? ((crc >> 1) ^ 16'hA001) : (crc >> 1);
    end
    return crc;
  endfunction

  task automatic build_expected(input logic [7:0] sa, input logic [7:0] fc, input int q);
    logic [15:0] crc;
    exp_buf[0] = sa;
    exp_buf[1] = fc;
    exp_buf[2] = 8'(2 * q);
    for (int w = 0; w < q; w++) begin
      exp_buf[3 + 2 * w] = mem[w][15:8];
      exp_buf[4 + 2 * w] = mem[w][7:0];
    end
    crc = crc_model(3 + 2 * q);
    exp_buf[3 + 2 * q] = crc[7:0];
    exp_buf[4 + 2 * q] = crc[15:8];
  endtask

  task automatic pulse_start(input bit fast, input logic [7:0] fc, input logic [7:0] q);
    @(negedge clk);
    if (fast) begin f_func = fc; f_qty = q; f_start = 1'b1; end
    else      begin d_func = fc; d_qty = q; d_start = 1'b1; end
    @(negedge clk);
    f_start = 1'b0;
    d_start = 1'b0;
  endtask

  // Samples the line every clock; bits must hold for exactly bitcyc clocks.
  task automatic capture_frame(input int nbytes, input int bitcyc, input int wait_max,
                               output int lat, output bit timed_out, output int bit_err,
                               output int en_err, output logic [2:0] done_seq);
    logic v0;
    lat = 0; timed_out = 1'b0; bit_err = 0; en_err = 0; done_seq = 3'b000;
    while (mon_en !== 1'b1) begin
      if (lat >= wait_max) begin timed_out = 1'b1; return; end
      @(negedge clk);
      lat++;
    end
    for (int b = 0; b < nbytes; b++) begin
      for (int k = 0; k < 10; k++) begin
        v0 = 1'bx;
        for (int c = 0; c < bitcyc; c++) begin
          if (!(b == 0 && k == 0 && c == 0)) @(negedge clk);
          if (mon_en !== 1'b1) en_err++;
          if (c == 0) v0 = mon_tx;
          else if (mon_tx !== v0) bit_err++;
        end
        if (k == 0 && v0 !== 1'b0) bit_err++;
        else if (k == 9 && v0 !== 1'b1) bit_err++;
        else if (k >= 1 && k <= 8) cap[b][k-1] = v0;
      end
    end
    @(negedge clk);
    if (mon_en !== 1'b0) en_err++;
    if (mon_tx !== 1'b1) bit_err++;
    done_seq[0] = mon_done;
    @(negedge clk);
    done_seq[1] = mon_done;
    @(negedge clk);
    done_seq[2] = mon_done;
  endtask

  task automatic test_reset();
    rst_d_n = 1'b0; rst_f_n = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++; if (d_tx !== 1'b1) begin n_fail++; $display("FAIL reset_tx got %b want 1", d_tx); end
    n_checks++; if (d_en !== 1'b0) begin n_fail++; $display("FAIL reset_en got %b want 0", d_en); end
    rst_d_n = 1'b1; rst_f_n = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++; if (d_done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", d_done); end
    n_checks++; if (d_addr !== 8'h00) begin n_fail++; $display("FAIL reset_addr got %h want 00", d_addr); end
    n_checks++; if (d_crc !== 16'hFFFF) begin n_fail++; $display("FAIL reset_crc got %h want FFFF", d_crc); end
    n_checks++; if (f_tx !== 1'b1 || f_en !== 1'b0) begin n_fail++; $display("FAIL reset_fast tx/en got %b%b want 10", f_tx, f_en); end
  endtask

  task automatic test_crc_engine();
    int stalls = 0;
    int w;
    @(negedge clk); c_clear = 1'b1;
    @(negedge clk); c_clear = 1'b0;
    n_checks++; if (c_crc !== 16'hFFFF) begin n_fail++; $display("FAIL crc_clear got %h want FFFF", c_crc); end
    for (int i = 0; i < 9; i++) begin
      w = 0;
      while (c_busy === 1'b1 && w < 20) begin @(negedge clk); w++; end
      if (w >= 20) stalls++;
      c_byte = 8'h31 + 8'(i); c_valid = 1'b1;
      @(negedge clk); c_valid = 1'b0;
    end
    w = 0;
    while (c_busy === 1'b1 && w < 20) begin @(negedge clk); w++; end
    if (w >= 20) stalls++;
    n_checks++; if (stalls != 0) begin n_fail++; $display("FAIL crc_busy_stuck got %0d stalls want 0", stalls); end
    n_checks++; if (c_crc !== 16'h4B37) begin n_fail++; $display("FAIL crc_123456789 got %h want 4B37", c_crc); end
  endtask

  task automatic test_frame_q4();
    int lat, berr, eerr, d0;
    bit to;
    logic [2:0] ds;
    logic [15:0] crc;
    use_fast = 1'b0;
    for (int i = 0; i < 11; i++) exp_buf[i] = q4_tab[i];
    crc = crc_model(11);
    repeat (3) @(negedge clk);
    n_checks++; if (d_tx !== 1'b1 || d_en !== 1'b0) begin n_fail++; $display("FAIL q4_idle_line got tx=%b en=%b want 1 0", d_tx, d_en); end
    d0 = done_cnt_d;
    pulse_start(1'b0, 8'h04, 8'h04);
    capture_frame(13, 434, 130, lat, to, berr, eerr, ds);
    n_checks++; if (to) begin n_fail++; $display("FAIL q4_en_timeout got no enable want enable"); end
    n_checks++; if (lat > 101) begin n_fail++; $display("FAIL q4_crc_latency got %0d want <=101", lat); end
    for (int i = 0; i < 11; i++) begin
      n_checks++; if (cap[i] !== q4_tab[i]) begin n_fail++; $display("FAIL q4_byte%0d got %h want %h", i, cap[i], q4_tab[i]); end
    end
    n_checks++; if (cap[11] !== crc[7:0]) begin n_fail++; $display("FAIL q4_crc_lo got %h want %h", cap[11], crc[7:0]); end
    n_checks++; if (cap[12] !== crc[15:8]) begin n_fail++; $display("FAIL q4_crc_hi got %h want %h", cap[12], crc[15:8]); end
    n_checks++; if (berr != 0) begin n_fail++; $display("FAIL q4_bit_timing got %0d errors want 0", berr); end
    n_checks++; if (eerr != 0) begin n_fail++; $display("FAIL q4_en_window got %0d errors want 0", eerr); end
    n_checks++; if (ds !== 3'b010) begin n_fail++; $display("FAIL q4_done_seq got %b want 010", ds); end
    n_checks++; if (done_cnt_d - d0 != 1) begin n_fail++; $display("FAIL q4_done_count got %0d want 1", done_cnt_d - d0); end
    n_checks++; if (d_crc !== crc) begin n_fail++; $display("FAIL q4_crc_calc got %h want %h", d_crc, crc); end
    n_checks++; if (d_addr !== 8'h00) begin n_fail++; $display("FAIL q4_addr_idle got %h want 00", d_addr); end
  endtask

  task automatic test_quantity_zero();
    int lat, berr, eerr, nz;
    bit to;
    logic [2:0] ds;
    use_fast = 1'b1;
    build_expected(8'h5A, 8'h03, 0);
    nz = 0;
    fork
      pulse_start(1'b1, 8'h03, 8'h00);
      begin
        repeat (700) begin @(negedge clk); if (f_addr !== 8'h00) nz++; end
      end
    join_any
    capture_frame(5, 8, 60, lat, to, berr, eerr, ds);
    wait fork;
    n_checks++; if (to) begin n_fail++; $display("FAIL q0_en_timeout got no enable want enable"); end
    for (int i = 0; i < 5; i++) begin
      n_checks++; if (cap[i] !== exp_buf[i]) begin n_fail++; $display("FAIL q0_byte%0d got %h want %h", i, cap[i], exp_buf[i]); end
    end
    n_checks++; if (berr != 0 || eerr != 0) begin n_fail++; $display("FAIL q0_timing got %0d/%0d want 0/0", berr, eerr); end
    n_checks++; if (nz != 0) begin n_fail++; $display("FAIL q0_addr_nonzero got %0d cycles want 0", nz); end
    n_checks++; if (ds !== 3'b010) begin n_fail++; $display("FAIL q0_done_seq got %b want 010", ds); end
  endtask

  task automatic test_back_to_back();
    int lat, berr, eerr, d0;
    bit to;
    logic [2:0] ds;
    logic was_sending;
    use_fast = 1'b1;
    build_expected(8'h5A, 8'h03, 2);
    d0 = done_cnt_f;
    was_sending = 1'b0;
    pulse_start(1'b1, 8'h03, 8'h02);
    fork
      capture_frame(9, 8, 100, lat, to, berr, eerr, ds);
      begin
        repeat (400) @(negedge clk);
        was_sending = f_en;
        f_func = 8'h06; f_qty = 8'h01; f_start = 1'b1;
        @(negedge clk);
        f_start = 1'b0;
      end
    join
    n_checks++; if (to || was_sending !== 1'b1) begin n_fail++; $display("FAIL b2b_first_send got to=%0d sending=%b want 0 1", to, was_sending); end
    for (int i = 0; i < 9; i++) begin
      prev[i] = cap[i];
      n_checks++; if (cap[i] !== exp_buf[i]) begin n_fail++; $display("FAIL b2b_first_byte%0d got %h want %h", i, cap[i], exp_buf[i]); end
    end
    n_checks++; if (done_cnt_f - d0 != 1) begin n_fail++; $display("FAIL b2b_done_count got %0d want 1", done_cnt_f - d0); end
    pulse_start(1'b1, 8'h03, 8'h02);
    capture_frame(9, 8, 100, lat, to, berr, eerr, ds);
    n_checks++; if (to) begin n_fail++; $display("FAIL b2b_second_timeout got no enable want enable"); end
    for (int i = 0; i < 9; i++) begin
      n_checks++; if (cap[i] !== prev[i]) begin n_fail++; $display("FAIL b2b_second_byte%0d got %h want %h", i, cap[i], prev[i]); end
    end
    n_checks++; if (berr != 0 || eerr != 0 || ds !== 3'b010) begin n_fail++; $display("FAIL b2b_second_timing got %0d/%0d/%b want 0/0/010", berr, eerr, ds); end
    n_checks++; if (f_addr !== 8'h00) begin n_fail++; $display("FAIL b2b_addr_idle got %h want 00", f_addr); end
  endtask

  task automatic test_reset_mid_frame();
    int lat, berr, eerr, d0, en_seen;
    bit to;
    logic [2:0] ds;
    use_fast = 1'b1;
    build_expected(8'h5A, 8'h03, 2);
    pulse_start(1'b1, 8'h03, 8'h02);
    repeat (300) @(negedge clk);
    n_checks++; if (f_en !== 1'b1) begin n_fail++; $display("FAIL rst_pre_sending got en=%b want 1", f_en); end
    #2 rst_f_n = 1'b0;
    #1;
    n_checks++; if (f_tx !== 1'b1 || f_en !== 1'b0) begin n_fail++; $display("FAIL rst_immediate got tx=%b en=%b want 1 0", f_tx, f_en); end
    n_checks++; if (f_crc !== 16'hFFFF || f_addr !== 8'h00) begin n_fail++; $display("FAIL rst_regs got crc=%h addr=%h want FFFF 00", f_crc, f_addr); end
    d0 = done_cnt_f;
    repeat (3) @(negedge clk);
    rst_f_n = 1'b1;
    en_seen = 0;
    repeat (800) begin @(negedge clk); if (f_en !== 1'b0) en_seen++; end
    n_checks++; if (done_cnt_f != d0) begin n_fail++; $display("FAIL rst_no_done got %0d pulses want 0", done_cnt_f - d0); end
    n_checks++; if (en_seen != 0) begin n_fail++; $display("FAIL rst_no_resume got %0d enabled cycles want 0", en_seen); end
    pulse_start(1'b1, 8'h03, 8'h02);
    capture_frame(9, 8, 100, lat, to, berr, eerr, ds);
    n_checks++; if (to) begin n_fail++; $display("FAIL rst_fresh_timeout got no enable want enable"); end
    for (int i = 0; i < 9; i++) begin
      n_checks++; if (cap[i] !== exp_buf[i]) begin n_fail++; $display("FAIL rst_fresh_byte%0d got %h want %h", i, cap[i], exp_buf[i]); end
    end
    n_checks++; if (berr != 0 || eerr != 0 || ds !== 3'b010) begin n_fail++; $display("FAIL rst_fresh_timing got %0d/%0d/%b want 0/0/010", berr, eerr, ds); end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    mem[0] = 16'h1235; mem[1] = 16'h2351; mem[2] = 16'h3516; mem[3] = 16'hAAAA;
    test_reset();
    test_crc_engine();
    test_frame_q4();
    test_quantity_zero();
    test_back_to_back();
    test_reset_mid_frame();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
